// File: rtl/sseg_bcd_counter.sv
// sseg_bcd_counter
//   Four-digit BCD up/down counter with a run/hold/idle control FSM, a
//   prescaler that sets the step rate, and registered seven-segment patterns
//   for a display multiplexer.
//
// Parameters
//   TICK_DIV : clk cycles per count step (>= 2)
//   BLANK_LZ : 1 blanks leading zeros; the units digit is always shown
//
// Ports
//   clk        : single clock, all state on the rising edge
//   rst        : synchronous active-high reset, overrides every other input
//   start_stop : one-cycle pulse, IDLE->RUN, RUN->HOLD, HOLD->RUN
//   clear      : one-cycle pulse, zeroes the count and returns to IDLE
//   up_dn      : 1 counts up, 0 counts down, sampled at each step
//   ssegValues : {thousands, hundreds, tens, units} active-low {g..a} patterns,
//                one cycle behind bcd
//   bcd        : {thousands, hundreds, tens, units} raw digits
//   running    : high while the FSM is in RUN
//   wrap       : one-cycle pulse after 9999->0000 or 0000->9999
module sseg_bcd_counter #(
  parameter int TICK_DIV = 1000000,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        up_dn,
  output logic [27:0] ssegValues,
  output logic [15:0] bcd,
  output logic        running,
  output logic        wrap
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   bcd_q, bcd_d;
  logic          wrap_q, wrap_d;
  logic          running_q, running_d;
  logic [27:0]   sseg_q;
  logic [16:0]   stepRes;

  // Ripple a +1 or -1 through the four digits; bit 16 is the carry/borrow
  // out of the thousands digit, i.e. the wrap condition.
  function automatic logic [16:0] bcdStep(input logic [15:0] v, input logic up);
    logic [15:0] r;
    logic        c;
    logic [3:0]  d;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = v[4*i +: 4];
      if (c) begin
        if (up) begin
          if (d == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = d + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            r[4*i +: 4] = 4'd9;
          end else begin
            r[4*i +: 4] = d - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return {c, r};
  endfunction

  function automatic logic [6:0] segOf(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // A digit is blanked only while it and every digit to its left are zero.
  function automatic logic [27:0] encode(input logic [15:0] v);
    logic bl3, bl2, bl1;
    bl3 = BLANK_LZ && (v[15:12] == 4'd0);
    bl2 = bl3 && (v[11:8] == 4'd0);
    bl1 = bl2 && (v[7:4] == 4'd0);
    return {bl3 ? 7'h7F : segOf(v[15:12]),
            bl2 ? 7'h7F : segOf(v[11:8]),
            bl1 ? 7'h7F : segOf(v[7:4]),
            segOf(v[3:0])};
  endfunction

  assign stepRes = bcdStep(bcd_q, up_dn);

  // Next-state logic. A step in RUN completes even when start_stop arrives in
  // the same cycle; clear is applied last so it wins over both.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    bcd_d   = bcd_q;
    wrap_d  = 1'b0;
    case (state_q)
      IDLE: begin
        presc_d = '0;
        if (start_stop) state_d = RUN;
      end
      RUN: begin
        if (presc_q == PMAX) begin
          presc_d = '0;
          bcd_d   = stepRes[15:0];
          wrap_d  = stepRes[16];
        end else begin
          presc_d = presc_q + PW'(1);
        end
        if (start_stop) state_d = HOLD;
      end
      HOLD: begin
        if (start_stop) state_d = RUN;
      end
      default: begin
        state_d = IDLE;
        presc_d = '0;
      end
    endcase
    if (clear) begin
      state_d = IDLE;
      presc_d = '0;
      bcd_d   = '0;
      wrap_d  = 1'b0;
    end
    running_d = (state_d == RUN);
  end

  // State registers; the segment register encodes the current bcd_q, which
  // is what gives ssegValues its one-cycle lag behind bcd.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      bcd_q     <= '0;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
      sseg_q    <= encode(16'h0000);
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      bcd_q     <= bcd_d;
      wrap_q    <= wrap_d;
      running_q <= running_d;
      sseg_q    <= encode(bcd_q);
    end
  end

  assign ssegValues = sseg_q;
  assign bcd        = bcd_q;
  assign running    = running_q;
  assign wrap       = wrap_q;

endmodule

// File: tb/tb_sseg_bcd_counter.sv
// tb_sseg_bcd_counter
//   Drives two counters (leading-zero blanking on and off) from the same
//   inputs and compares every cycle against a model that keeps the count as a
//   plain integer 0..9999 and the control state as a small mode number.
module tb_sseg_bcd_counter;

  localparam int TICK = 4;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_stop = 1'b0;
  logic        clear = 1'b0;
  logic        up_dn = 1'b1;
  logic [27:0] sseg1, sseg0;
  logic [15:0] bcd1, bcd0;
  logic        run1, run0, wrap1, wrap0;

  int checks = 0;
  int fails  = 0;

  int mMode = M_IDLE;
  int mCount = 0;
  int mRunCycles = 0;
  int mSsegCount = 0;
  bit mWrap = 1'b0;

  always #5 clk = ~clk;

  sseg_bcd_counter #(.TICK_DIV(TICK), .BLANK_LZ(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .up_dn(up_dn),
    .ssegValues(sseg1), .bcd(bcd1), .running(run1), .wrap(wrap1)
  );

  sseg_bcd_counter #(.TICK_DIV(TICK), .BLANK_LZ(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .up_dn(up_dn),
    .ssegValues(sseg0), .bcd(bcd0), .running(run0), .wrap(wrap0)
  );

  function automatic logic [6:0] segOf(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic logic [27:0] expSseg(input int c, input bit blank);
    logic [6:0] s3, s2, s1;
    s3 = (blank && c < 1000) ? 7'h7F : segOf(c / 1000);
    s2 = (blank && c < 100)  ? 7'h7F : segOf((c / 100) % 10);
    s1 = (blank && c < 10)   ? 7'h7F : segOf((c / 10) % 10);
    return {s3, s2, s1, segOf(c % 10)};
  endfunction

  function automatic logic [15:0] expBcd(input int c);
    return {4'(c / 1000), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model of one clock edge, written from the counter's behaviour: the count
  // advances once every TICK cycles spent in RUN.
  task automatic modelEdge(input bit r, input bit ss, input bit clr, input bit ud);
    if (r) begin
      mMode = M_IDLE; mCount = 0; mRunCycles = 0; mWrap = 1'b0; mSsegCount = 0;
    end else begin
      mSsegCount = mCount;
      mWrap = 1'b0;
      if (clr) begin
        mMode = M_IDLE; mCount = 0; mRunCycles = 0;
      end else begin
        if (mMode == M_RUN) begin
          mRunCycles++;
          if (mRunCycles == TICK) begin
            mRunCycles = 0;
            if (ud) begin
              mWrap = (mCount == 9999);
              mCount = (mCount + 1) % 10000;
            end else begin
              mWrap = (mCount == 0);
              mCount = (mCount + 9999) % 10000;
            end
          end
        end
        if (ss) mMode = (mMode == M_RUN) ? M_HOLD : M_RUN;
      end
    end
  endtask

  task automatic applyStimulus(input string tag, input bit r, input bit ss, input bit clr, input bit ud);
    rst = r; start_stop = ss; clear = clr; up_dn = ud;
    @(posedge clk);
    modelEdge(r, ss, clr, ud);
    #1;
    checkOutput({tag, ".bcd1"}, 32'(bcd1), 32'(expBcd(mCount)));
    checkOutput({tag, ".bcd0"}, 32'(bcd0), 32'(expBcd(mCount)));
    checkOutput({tag, ".running"}, 32'(run1), 32'(mMode == M_RUN));
    checkOutput({tag, ".wrap"}, 32'(wrap1), 32'(mWrap));
    checkOutput({tag, ".wrap0"}, 32'(wrap0), 32'(mWrap));
    checkOutput({tag, ".sseg1"}, 32'(sseg1), 32'(expSseg(mSsegCount, 1'b1)));
    checkOutput({tag, ".sseg0"}, 32'(sseg0), 32'(expSseg(mSsegCount, 1'b0)));
    rst = 1'b0; start_stop = 1'b0; clear = 1'b0;
  endtask

  task automatic runCycles(input string tag, input int n, input bit ud);
    for (int i = 0; i < n; i++) applyStimulus(tag, 1'b0, 1'b0, 1'b0, ud);
  endtask

  initial begin
    // Reset state
    applyStimulus("rst", 1'b1, 1'b1, 1'b1, 1'b1);
    applyStimulus("rst", 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("rst.presc", 32'(dut1.presc_q), 32'd0);
    checkOutput("rst.ssegPattern", 32'(sseg1), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));

    // Count up ten steps in 40 cycles
    applyStimulus("up.start", 1'b0, 1'b1, 1'b0, 1'b1);
    runCycles("up", 40, 1'b1);
    checkOutput("up.bcd10", 32'(bcd1), 32'h0010);
    runCycles("up.lag", 1, 1'b1);
    checkOutput("up.sseg10", 32'(sseg1), 32'({7'h7F, 7'h7F, 7'b1111001, 7'b1000000}));

    // Wrap in both directions
    applyStimulus("wrap.clr", 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus("wrap.start", 1'b0, 1'b1, 1'b0, 1'b0);
    runCycles("wrap.dn", 4, 1'b0);
    checkOutput("wrap.dn9999", 32'(bcd1), 32'h9999);
    checkOutput("wrap.dnPulse", 32'(wrap1), 32'd1);
    runCycles("wrap.up", 4, 1'b1);
    checkOutput("wrap.up0000", 32'(bcd1), 32'h0000);
    checkOutput("wrap.upPulse", 32'(wrap1), 32'd1);
    runCycles("wrap.after", 1, 1'b1);
    checkOutput("wrap.oneCycle", 32'(wrap1), 32'd0);

    // Hold partway into a period, then resume
    applyStimulus("hold.stop", 1'b0, 1'b1, 1'b0, 1'b1);
    runCycles("hold.wait", 20, 1'b1);
    checkOutput("hold.frozen", 32'(bcd1), 32'h0000);
    applyStimulus("hold.resume", 1'b0, 1'b1, 1'b0, 1'b1);
    runCycles("hold.run1", 1, 1'b1);
    checkOutput("hold.noStepYet", 32'(bcd1), 32'h0000);
    runCycles("hold.run2", 1, 1'b1);
    checkOutput("hold.stepAfter2", 32'(bcd1), 32'h0001);

    // Clear and start_stop together in RUN, on a step cycle
    runCycles("clr.run", 3, 1'b1);
    applyStimulus("clr.both", 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("clr.bcd", 32'(bcd1), 32'h0000);
    checkOutput("clr.running", 32'(run1), 32'd0);
    checkOutput("clr.wrap", 32'(wrap1), 32'd0);
    runCycles("clr.idle", 8, 1'b1);

    // 0105 with and without blanking
    applyStimulus("lz.rst", 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus("lz.start", 1'b0, 1'b1, 1'b0, 1'b1);
    runCycles("lz", 420, 1'b1);
    checkOutput("lz.bcd0105", 32'(bcd0), 32'h0105);
    runCycles("lz.lag", 1, 1'b1);
    checkOutput("lz.noBlank", 32'(sseg0), 32'({7'b1000000, 7'b1111001, 7'b1000000, 7'b0010010}));
    checkOutput("lz.blank", 32'(sseg1), 32'({7'h7F, 7'b1111001, 7'b1000000, 7'b0010010}));

    // Reset in the middle of RUN
    applyStimulus("mid.rst", 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus("mid.start", 1'b0, 1'b1, 1'b0, 1'b1);
    runCycles("mid", 148, 1'b1);
    checkOutput("mid.bcd0037", 32'(bcd1), 32'h0037);
    applyStimulus("mid.abort", 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("mid.bcd", 32'(bcd1), 32'h0000);
    checkOutput("mid.running", 32'(run1), 32'd0);
    checkOutput("mid.presc", 32'(dut1.presc_q), 32'd0);
    checkOutput("mid.wrap", 32'(wrap1), 32'd0);
    runCycles("mid.after", 1, 1'b1);
    checkOutput("mid.ssegPattern", 32'(sseg1), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));

    // Randomized traffic against the model
    begin
      bit ud;
      ud = 1'b1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 29) == 0) ud = ~ud;
        applyStimulus("rand",
                      $urandom_range(0, 299) == 0,
                      $urandom_range(0, 24) == 0,
                      $urandom_range(0, 99) == 0,
                      ud);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/sseg_bcd_counter.md
SSEG_BCD_COUNTER -- requirements
Module: sseg_bcd_counter

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 1000000, prescaler divide ratio in clk cycles per count step; legal range is at least 2.
REQ-002 The block SHALL have parameter BLANK_LZ, default 1, where 1 enables leading-zero blanking.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start_stop, input, 1 bit: a one-cycle pulse that toggles run/hold.
REQ-006 The block SHALL have port clear, input, 1 bit: a one-cycle pulse that zeroes the count and returns to IDLE.
REQ-007 The block SHALL have port up_dn, input, 1 bit: 1 counts up and 0 counts down, sampled at each step.
REQ-008 The block SHALL have port ssegValues, output, 28 bits: four 7-bit segment patterns; thousands in [27:21], hundreds in [20:14], tens in [13:7], units in [6:0]; feeds the display multiplexer directly.
REQ-009 The block SHALL have port bcd, output, 16 bits: the raw digits {thousands, hundreds, tens, units}, 4 bits each.
REQ-010 The block SHALL have port running, output, 1 bit: high while in RUN.
REQ-011 The block SHALL have port wrap, output, 1 bit: a one-cycle pulse on 9999->0000 or 0000->9999.

Function
REQ-012 The FSM SHALL have states IDLE, RUN and HOLD.
REQ-013 The FSM SHALL make these transitions on start_stop: IDLE->RUN, RUN->HOLD, HOLD->RUN.
REQ-014 clear SHALL force IDLE from any state; clear SHALL take priority over a simultaneous start_stop.
REQ-015 The prescaler SHALL count 0..TICK_DIV-1 only in RUN, SHALL hold its value in HOLD, and SHALL be zeroed in IDLE.
REQ-016 A step SHALL occur in the cycle the prescaler equals TICK_DIV-1 while in RUN; the prescaler SHALL wrap to 0 in that same cycle.
REQ-017 A start_stop pulse arriving in a step cycle SHALL still let that step complete, and the state SHALL then change.
REQ-018 An up step SHALL increment BCD with decimal carry, with each digit limited to 0..9; 9999 SHALL go to 0000 and pulse wrap.
REQ-019 A down step SHALL decrement BCD with decimal borrow; 0000 SHALL go to 9999 and pulse wrap.
REQ-020 bcd SHALL update on the clock edge that ends the step cycle; wrap SHALL be asserted for exactly that following cycle.
REQ-021 ssegValues SHALL be registered and lag bcd by exactly one cycle.
REQ-022 Segment encoding SHALL be active-low, bit order {g,f,e,d,c,b,a}: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-023 A blank digit SHALL be 1111111.
REQ-024 With BLANK_LZ=1, a digit SHALL be blanked when it and all digits to its left are 0; the units digit SHALL never be blanked.
REQ-025 With BLANK_LZ=0, no digit SHALL be blanked.
REQ-026 A clear SHALL zero the digits on the next edge; ssegValues SHALL show 0 one cycle later, and wrap SHALL NOT be asserted.
REQ-027 Changing up_dn SHALL take effect at the next step only; it SHALL NOT reset the prescaler.
REQ-028 running SHALL be a registered decode of the state, so running=1 exactly while the state is RUN.

Reset
REQ-029 With rst high at an edge, the block SHALL enter IDLE and set prescaler=0, bcd=16'h0000, wrap=0 and running=0.
REQ-030 With rst high at an edge and BLANK_LZ=1, ssegValues SHALL become {1111111,1111111,1111111,1000000}.
REQ-031 rst SHALL override clear and start_stop.
REQ-032 A reset mid-RUN SHALL abort the count, with no wrap pulse.

Verification
REQ-033 The bench SHALL cover this scenario: TICK_DIV=4, reset, start_stop pulse, up_dn=1, 40 cycles -> bcd=0010, steps every 4 cycles, ssegValues {blank,blank,1111001,1000000} one cycle after bcd.
REQ-034 The bench SHALL cover this scenario: preload to 9999 via down count from 0000 (one step), then up_dn=1 for one step -> 0000->9999 with wrap pulse, then 9999->0000 with wrap pulse, each exactly one cycle.
REQ-035 The bench SHALL cover this scenario: start_stop to HOLD 2 cycles into a period, hold 20 cycles, resume -> next step exactly 2 cycles after resume, and bcd unchanged while in HOLD.
REQ-036 The bench SHALL cover this scenario: clear and start_stop in the same cycle while in RUN -> IDLE, bcd=0000, running=0, no wrap.
REQ-037 The bench SHALL cover this scenario: BLANK_LZ=0, count to 0105 -> ssegValues {1000000,1111001,1000000,0010010}; with BLANK_LZ=1 -> {1111111,1111001,1000000,0010010}.
REQ-038 The bench SHALL cover this scenario: rst asserted mid-RUN at bcd=0037 -> next cycle bcd=0000, running=0, prescaler=0, and the reset ssegValues pattern one cycle later.
